i2s_tx_feeder: RTL and testbench
================================

Name: i2s_tx_feeder

Overview:
- Upstream stage of the I2S transmitter: buffers stereo frames from a valid/ready producer in a small synchronous FIFO.
- Drives the transmitter's parallel `left_chan`/`right_chan` inputs.
- Observes the transmitter's `lrclk` to detect each frame hand-off and advance to the next frame.
- Runs on posedge `sclk`; the transmitter runs on negedge `sclk`.

Parameters:
- AUDIO_DW, 32, bits per channel sample; must match the transmitter.
- DEPTH_LOG2, 3, log2 of FIFO depth in stereo frames (default 8 frames).
- UNDERRUN_REPEAT, 0, 0 = load zeros on underrun; 1 = hold (repeat) the last frame.

Ports:
- sclk  in  1  bit clock, shared with the transmitter; all logic on its posedge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = stream from the FIFO; 0 = output silence, FIFO untouched.
- mute  in  1  1 = pop as normal but present zeros.
- flush  in  1  synchronous FIFO clear.
- s_valid  in  1  producer frame valid.
- s_ready  out  1  feeder can accept a frame.
- s_left  in  AUDIO_DW  producer left sample.
- s_right  in  AUDIO_DW  producer right sample.
- lrclk  in  1  transmitter word select (0 = left, 1 = right).
- left_chan  out  AUDIO_DW  current left frame to the transmitter.
- right_chan  out  AUDIO_DW  current right frame to the transmitter.
- fifo_level  out  DEPTH_LOG2+1  frames currently stored (0..2^DEPTH_LOG2).
- underrun  out  1  one-cycle pulse on an underrun.
- underrun_cnt  out  16  saturating count of underruns.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - left_chan = right_chan = 0, fifo_level = 0, underrun = 0, underrun_cnt = 0.
  - Internal lrclk_q = 1, matching the transmitter's reset value of lrclk.
  - FIFO pointers = 0.
  - s_ready = 0 while in reset, then 1 while not full.
- Frame tick:
  - tick = lrclk_q & ~lrclk, evaluated at posedge sclk; lrclk_q <= lrclk every cycle.
  - The tick marks the posedge following the transmitter's capture of left_chan/right_chan.
  - Outputs are updated on the tick edge and are stable for the next 2*AUDIO_DW-1 cycles before the next capture.
- Push: on s_valid & s_ready, the frame {s_left, s_right} is written.
  - s_ready = !full; no bypass when full, so a simultaneous pop while full does not admit a push that cycle.
- On tick, in priority order:
  - enable=0: load zeros; no pop, no underrun.
  - FIFO non-empty (registered count, before this cycle's push): pop the head; load zeros if mute=1, else the head frame.
  - FIFO empty: underrun=1 and underrun_cnt+1, saturating at 16'hFFFF; load zeros, or hold the current outputs if UNDERRUN_REPEAT=1.
- Simultaneous push and tick:
  - Empty FIFO plus push on the tick cycle: counts as an underrun, and the pushed frame is played on the next tick.
  - Non-empty FIFO: push and pop both occur; fifo_level is unchanged.
- flush=1:
  - Pointers and count are cleared; this has priority over push and pop in the same cycle.
  - The tick logic still runs and sees the FIFO as empty, so a tick during flush underruns.
  - Outputs and underrun_cnt are not cleared.
- Pointer arithmetic: pointers are DEPTH_LOG2+1 bits.
  - Wrap-around is natural modulo 2^(DEPTH_LOG2+1).
  - full = MSBs differ and the low bits are equal; empty = the pointers are equal.
- fifo_level is registered and reflects push/pop/flush one cycle after the edge.
- No latency from push to availability beyond one cycle: a frame pushed at edge N is poppable by a tick at edge N+1.

Decomposition:
- Shared package i2s_pkg:
  - AUDIO_DW default constant.
  - Stereo frame typedef {left, right} sized 2*AUDIO_DW.
  - Underrun mode constants (ZERO = 0, REPEAT = 1).
- Sub-module i2s_sync_fifo: generic single-clock FIFO of frames, parameterised by width and DEPTH_LOG2, with push/pop/flush, full/empty/level.
- i2s_tx_feeder contains the tick detector, the output registers and the underrun logic.

Test Plan:
- Reset, then 3 ticks with no pushes: outputs stay 0; underrun pulses 3 times; underrun_cnt = 3.
- Push frames (L=32'h1111_0001, R=32'hAAAA_0001) through (L=32'h1111_0004, R=32'hAAAA_0004), then drive the transmitter: outputs change to frames 1..4 in order on successive lrclk falls; fifo_level goes 4→0; no underrun.
- Push 9 frames back-to-back with DEPTH_LOG2=3: s_ready drops after the 8th frame, and fifo_level = 8 with no wrap corruption; after 1 tick s_ready=1 and fifo_level=7. Repeat over 20 frames to cross the pointer wrap; the data order is preserved.
- UNDERRUN_REPEAT=1, FIFO drained after frame L=32'h0000_00AB: the next tick holds L=32'h0000_00AB; underrun=1.
- mute=1 with 2 frames queued: 2 ticks give outputs 0 and fifo_level 2→0; enable=0 with 2 frames queued: outputs 0 and fifo_level stays 2.
- Assert rst_n=0 mid-frame with 5 frames queued: immediate outputs 0, fifo_level 0, underrun_cnt 0. flush on a tick cycle: fifo_level becomes 0, underrun=1.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit path: default sample width,
// stereo frame layout, underrun modes and a saturating counter helper.
package i2s_pkg;

  localparam int I2S_AUDIO_DW = 32;

  // One stereo frame as it travels through the feeder FIFO.
  typedef struct packed {
    logic [I2S_AUDIO_DW-1:0] left;
    logic [I2S_AUDIO_DW-1:0] right;
  } stereo_frame_t;

  // What the feeder presents when a frame boundary finds the FIFO empty.
  localparam int UR_ZERO   = 0;
  localparam int UR_REPEAT = 1;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/i2s_sync_fifo.sv
// Single-clock FIFO of fixed-width words. Pointers carry one extra bit so
// full and empty are distinguishable; the head word is read combinationally
// so a word written on one edge can be popped on the very next edge.
module i2s_sync_fifo #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_reg;
  logic [DEPTH_LOG2:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0] count_reg;
  logic                do_push;
  logic                do_pop;

  assign full  = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                 (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  // Full blocks writes and empty blocks reads; the caller may request freely.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_data = mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
  assign level     = count_reg;

  // Pointer and occupancy registers; flush overrides any push/pop this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage array; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2s_tx_feeder.sv
// Feeds stereo frames to an I2S transmitter. Frames from a valid/ready
// producer are queued; each falling edge of the transmitter's lrclk (seen
// on posedge sclk) marks a frame hand-off, and the next frame is loaded
// onto left_chan/right_chan so it is stable well before the next capture.
module i2s_tx_feeder
  import i2s_pkg::*;
#(
  parameter int AUDIO_DW        = I2S_AUDIO_DW,
  parameter int DEPTH_LOG2      = 3,
  parameter int UNDERRUN_REPEAT = UR_ZERO
) (
  input  logic                  sclk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  mute,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [AUDIO_DW-1:0]   s_left,
  input  logic [AUDIO_DW-1:0]   s_right,
  input  logic                  lrclk,
  output logic [AUDIO_DW-1:0]   left_chan,
  output logic [AUDIO_DW-1:0]   right_chan,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt
);

  logic                  lrclk_q_reg;
  logic                  ready_en_reg;
  logic                  tick;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_avail;
  logic [2*AUDIO_DW-1:0] head_data;
  logic [AUDIO_DW-1:0]   left_reg;
  logic [AUDIO_DW-1:0]   right_reg;
  logic [AUDIO_DW-1:0]   left_next;
  logic [AUDIO_DW-1:0]   right_next;
  logic                  underrun_reg;
  logic                  underrun_next;
  logic [15:0]           underrun_cnt_reg;
  logic [15:0]           underrun_cnt_next;

  // lrclk falling between two edges: the transmitter just took the frame.
  assign tick = lrclk_q_reg & ~lrclk;

  // ready_en_reg keeps s_ready low while reset is held and for the edge after.
  assign s_ready = ready_en_reg & ~fifo_full;
  assign push    = s_valid & s_ready;

  // A flush in progress makes the queue look empty to the hand-off logic.
  assign fifo_avail = ~fifo_empty & ~flush;
  assign pop        = tick & enable & fifo_avail;

  i2s_sync_fifo #(
    .WIDTH      (2*AUDIO_DW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (sclk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data ({s_left, s_right}),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Choose what the transmitter sees next and whether this hand-off starved.
  always_comb begin
    left_next         = left_reg;
    right_next        = right_reg;
    underrun_next     = 1'b0;
    underrun_cnt_next = underrun_cnt_reg;
    if (tick) begin
      if (!enable) begin
        left_next  = '0;
        right_next = '0;
      end else if (fifo_avail) begin
        if (mute) begin
          left_next  = '0;
          right_next = '0;
        end else begin
          left_next  = head_data[2*AUDIO_DW-1 -: AUDIO_DW];
          right_next = head_data[AUDIO_DW-1:0];
        end
      end else begin
        underrun_next     = 1'b1;
        underrun_cnt_next = sat_inc16(underrun_cnt_reg);
        if (UNDERRUN_REPEAT != UR_REPEAT) begin
          left_next  = '0;
          right_next = '0;
        end
      end
    end
  end

  // Output, edge-detect and underrun registers.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      lrclk_q_reg      <= 1'b1;
      ready_en_reg     <= 1'b0;
      left_reg         <= '0;
      right_reg        <= '0;
      underrun_reg     <= 1'b0;
      underrun_cnt_reg <= '0;
    end else begin
      lrclk_q_reg      <= lrclk;
      ready_en_reg     <= 1'b1;
      left_reg         <= left_next;
      right_reg        <= right_next;
      underrun_reg     <= underrun_next;
      underrun_cnt_reg <= underrun_cnt_next;
    end
  end

  assign left_chan    = left_reg;
  assign right_chan   = right_reg;
  assign underrun     = underrun_reg;
  assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_i2s_tx_feeder.sv
// Directed bench for i2s_tx_feeder: a table of per-cycle vectors covering
// underrun, streaming, enable/mute, simultaneous push/tick, flush and full,
// then a modelled stream across the pointer wrap, the repeat-on-underrun
// variant and an asynchronous reset with frames queued.
module tb_i2s_tx_feeder;
  import i2s_pkg::*;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic        enable, mute, flush, s_valid, s_ready, lrclk, underrun;
  logic [31:0] s_left, s_right, left_chan, right_chan;
  logic [3:0]  fifo_level;
  logic [15:0] underrun_cnt;

  logic        r_enable, r_mute, r_flush, r_valid, r_ready, r_lrclk, r_underrun;
  logic [31:0] r_s_left, r_s_right, r_left_chan, r_right_chan;
  logic [3:0]  r_level;
  logic [15:0] r_underrun_cnt;

  always #5 sclk = ~sclk;

  i2s_tx_feeder #(.AUDIO_DW(32), .DEPTH_LOG2(3), .UNDERRUN_REPEAT(UR_ZERO)) dut (
    .sclk(sclk), .rst_n(rst_n), .enable(enable), .mute(mute), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .lrclk(lrclk), .left_chan(left_chan), .right_chan(right_chan),
    .fifo_level(fifo_level), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  i2s_tx_feeder #(.AUDIO_DW(32), .DEPTH_LOG2(3), .UNDERRUN_REPEAT(UR_REPEAT)) dut_rep (
    .sclk(sclk), .rst_n(rst_n), .enable(r_enable), .mute(r_mute), .flush(r_flush),
    .s_valid(r_valid), .s_ready(r_ready), .s_left(r_s_left), .s_right(r_s_right),
    .lrclk(r_lrclk), .left_chan(r_left_chan), .right_chan(r_right_chan),
    .fifo_level(r_level), .underrun(r_underrun), .underrun_cnt(r_underrun_cnt)
  );

  typedef struct {
    logic        v;
    logic [31:0] l, r;
    logic        lr, en, mu, fl;
    logic [31:0] el, er;
    logic [3:0]  elev;
    logic        eur;
    logic [15:0] ecnt;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic v, input logic [31:0] l, input logic [31:0] r,
                              input logic lr, input logic en, input logic mu, input logic fl,
                              input logic [31:0] el, input logic [31:0] er, input logic [3:0] elev,
                              input logic eur, input logic [15:0] ecnt, input logic erdy);
    vec_t t;
    t.v = v; t.l = l; t.r = r; t.lr = lr; t.en = en; t.mu = mu; t.fl = fl;
    t.el = el; t.er = er; t.elev = elev; t.eur = eur; t.ecnt = ecnt; t.erdy = erdy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  initial begin
    stereo_frame_t q[$];
    stereo_frame_t f;
    logic [31:0]   el, er;
    logic [15:0]   ecnt;
    logic          lr_prev, tk, acc, eur;
    int            pushed, sz;

    rst_n = 1'b0; enable = 1'b1; mute = 1'b0; flush = 1'b0; s_valid = 1'b0;
    s_left = '0; s_right = '0; lrclk = 1'b1;
    r_enable = 1'b1; r_mute = 1'b0; r_flush = 1'b0; r_valid = 1'b0;
    r_s_left = '0; r_s_right = '0; r_lrclk = 1'b1;

    // ---------------- vector table ----------------
    // 3 ticks with nothing queued
    for (int k = 1; k <= 3; k++) begin
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 4'd0, 1, 16'(k), 1));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 4'd0, 0, 16'(k), 1));
    end
    // 4 frames streamed in order
    for (int k = 1; k <= 4; k++)
      vecs.push_back(mk(1, 32'h1111_0000 + 32'(k), 32'hAAAA_0000 + 32'(k), 1, 1, 0, 0,
                        0, 0, 4'(k), 0, 16'd3, 1));
    for (int k = 1; k <= 4; k++) begin
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h1111_0000 + 32'(k), 32'hAAAA_0000 + 32'(k),
                        4'(4 - k), 0, 16'd3, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 32'h1111_0000 + 32'(k), 32'hAAAA_0000 + 32'(k),
                        4'(4 - k), 0, 16'd3, 1));
    end
    // enable=0: silence, queue untouched; then resume
    vecs.push_back(mk(1, 32'h3333_0001, 32'hCCCC_0001, 1, 1, 0, 0, 32'h1111_0004, 32'hAAAA_0004, 4'd1, 0, 16'd3, 1));
    vecs.push_back(mk(1, 32'h3333_0002, 32'hCCCC_0002, 1, 1, 0, 0, 32'h1111_0004, 32'hAAAA_0004, 4'd2, 0, 16'd3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd2, 0, 16'd3, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 4'd2, 0, 16'd3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h3333_0001, 32'hCCCC_0001, 4'd1, 0, 16'd3, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 32'h3333_0001, 32'hCCCC_0001, 4'd1, 0, 16'd3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h3333_0002, 32'hCCCC_0002, 4'd0, 0, 16'd3, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 32'h3333_0002, 32'hCCCC_0002, 4'd0, 0, 16'd3, 1));
    // mute: pops continue, zeros presented
    vecs.push_back(mk(1, 32'h2222_0001, 32'hBBBB_0001, 1, 1, 0, 0, 32'h3333_0002, 32'hCCCC_0002, 4'd1, 0, 16'd3, 1));
    vecs.push_back(mk(1, 32'h2222_0002, 32'hBBBB_0002, 1, 1, 0, 0, 32'h3333_0002, 32'hCCCC_0002, 4'd2, 0, 16'd3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 4'd1, 0, 16'd3, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 4'd1, 0, 16'd3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 4'd0, 0, 16'd3, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 4'd0, 0, 16'd3, 1));
    // push on a tick with empty queue: underrun, frame plays next tick
    vecs.push_back(mk(1, 32'h4444_0001, 32'hEEEE_0001, 0, 1, 0, 0, 0, 0, 4'd1, 1, 16'd4, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 4'd1, 0, 16'd4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h4444_0001, 32'hEEEE_0001, 4'd0, 0, 16'd4, 1));
    // push and pop together on a non-empty queue: level unchanged
    vecs.push_back(mk(1, 32'h4444_0002, 32'hEEEE_0002, 1, 1, 0, 0, 32'h4444_0001, 32'hEEEE_0001, 4'd1, 0, 16'd4, 1));
    vecs.push_back(mk(1, 32'h4444_0003, 32'hEEEE_0003, 0, 1, 0, 0, 32'h4444_0002, 32'hEEEE_0002, 4'd1, 0, 16'd4, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 32'h4444_0002, 32'hEEEE_0002, 4'd1, 0, 16'd4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h4444_0003, 32'hEEEE_0003, 4'd0, 0, 16'd4, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 32'h4444_0003, 32'hEEEE_0003, 4'd0, 0, 16'd4, 1));
    // flush on a tick (with a push attempt): cleared, underrun
    vecs.push_back(mk(1, 32'h5555_0001, 32'hFFFF_0001, 1, 1, 0, 0, 32'h4444_0003, 32'hEEEE_0003, 4'd1, 0, 16'd4, 1));
    vecs.push_back(mk(1, 32'h5555_0002, 32'hFFFF_0002, 1, 1, 0, 0, 32'h4444_0003, 32'hEEEE_0003, 4'd2, 0, 16'd4, 1));
    vecs.push_back(mk(1, 32'h5555_0003, 32'hFFFF_0003, 0, 1, 0, 1, 0, 0, 4'd0, 1, 16'd5, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 4'd0, 0, 16'd5, 1));
    // fill to 8, 9th refused, tick frees a slot without bypass
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1, 32'h6666_0000 + 32'(k), 32'hDDDD_0000 + 32'(k), 1, 1, 0, 0,
                        0, 0, 4'(k), 0, 16'd5, (k < 8) ? 1'b1 : 1'b0));
    vecs.push_back(mk(1, 32'h6666_0009, 32'hDDDD_0009, 1, 1, 0, 0, 0, 0, 4'd8, 0, 16'd5, 0));
    vecs.push_back(mk(1, 32'h6666_0009, 32'hDDDD_0009, 0, 1, 0, 0, 32'h6666_0001, 32'hDDDD_0001, 4'd7, 0, 16'd5, 1));
    vecs.push_back(mk(1, 32'h6666_0009, 32'hDDDD_0009, 1, 1, 0, 0, 32'h6666_0001, 32'hDDDD_0001, 4'd8, 0, 16'd5, 0));

    // ---------------- reset state ----------------
    #2;
    chk("rst left", left_chan, 32'h0);
    chk("rst right", right_chan, 32'h0);
    chk("rst level", 32'(fifo_level), 32'd0);
    chk("rst underrun", 32'(underrun), 32'd0);
    chk("rst cnt", 32'(underrun_cnt), 32'd0);
    chk("rst ready", 32'(s_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post-rst ready", 32'(s_ready), 32'd1);
    $display("reset released, ready=%0d level=%0d", s_ready, fifo_level);

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      s_valid = vecs[i].v; s_left = vecs[i].l; s_right = vecs[i].r;
      lrclk = vecs[i].lr; enable = vecs[i].en; mute = vecs[i].mu; flush = vecs[i].fl;
      step();
      chk($sformatf("v%0d left", i), left_chan, vecs[i].el);
      chk($sformatf("v%0d right", i), right_chan, vecs[i].er);
      chk($sformatf("v%0d level", i), 32'(fifo_level), 32'(vecs[i].elev));
      chk($sformatf("v%0d underrun", i), 32'(underrun), 32'(vecs[i].eur));
      chk($sformatf("v%0d cnt", i), 32'(underrun_cnt), 32'(vecs[i].ecnt));
      chk($sformatf("v%0d ready", i), 32'(s_ready), 32'(vecs[i].erdy));
      $display("vec %0d: lr=%0d L=%h R=%h level=%0d ur=%0d cnt=%0d", i, lrclk,
               left_chan, right_chan, fifo_level, underrun, underrun_cnt);
    end
    flush = 1'b0; mute = 1'b0; enable = 1'b1;

    // ---------------- stream across the pointer wrap ----------------
    for (int k = 2; k <= 9; k++) begin
      f.left = 32'h6666_0000 + 32'(k);
      f.right = 32'hDDDD_0000 + 32'(k);
      q.push_back(f);
    end
    el = 32'h6666_0001; er = 32'hDDDD_0001; ecnt = 16'd5; lr_prev = 1'b1; pushed = 0;
    for (int c = 0; c < 80; c++) begin
      lrclk   = (c % 2 == 0) ? 1'b0 : 1'b1;
      s_valid = (pushed < 20);
      s_left  = 32'h7777_0000 + 32'(pushed);
      s_right = 32'h8888_0000 + 32'(pushed);
      tk  = lr_prev & ~lrclk;
      sz  = q.size();
      acc = s_valid && (sz < 8);
      eur = 1'b0;
      step();
      if (tk) begin
        if (sz > 0) begin
          f = q.pop_front();
          el = f.left; er = f.right;
        end else begin
          el = '0; er = '0; eur = 1'b1;
          if (ecnt != 16'hFFFF) ecnt++;
        end
      end
      if (acc) begin
        f.left = s_left; f.right = s_right;
        q.push_back(f);
        pushed++;
      end
      lr_prev = lrclk;
      chk($sformatf("s%0d left", c), left_chan, el);
      chk($sformatf("s%0d right", c), right_chan, er);
      chk($sformatf("s%0d level", c), 32'(fifo_level), 32'(q.size()));
      chk($sformatf("s%0d underrun", c), 32'(underrun), 32'(eur));
      chk($sformatf("s%0d cnt", c), 32'(underrun_cnt), 32'(ecnt));
      chk($sformatf("s%0d ready", c), 32'(s_ready), (q.size() < 8) ? 32'd1 : 32'd0);
      $display("stream %0d: L=%h R=%h level=%0d ur=%0d", c, left_chan, right_chan, fifo_level, underrun);
    end
    s_valid = 1'b0; lrclk = 1'b1;

    // ---------------- repeat-on-underrun variant ----------------
    r_valid = 1'b1; r_s_left = 32'h0000_00AB; r_s_right = 32'h0000_00CD; r_lrclk = 1'b1;
    step();
    chk("rep level1", 32'(r_level), 32'd1);
    r_valid = 1'b0; r_lrclk = 1'b0;
    step();
    chk("rep play left", r_left_chan, 32'h0000_00AB);
    chk("rep play ur", 32'(r_underrun), 32'd0);
    chk("rep level0", 32'(r_level), 32'd0);
    r_lrclk = 1'b1;
    step();
    r_lrclk = 1'b0;
    step();
    chk("rep hold left", r_left_chan, 32'h0000_00AB);
    chk("rep hold right", r_right_chan, 32'h0000_00CD);
    chk("rep hold ur", 32'(r_underrun), 32'd1);
    chk("rep hold cnt", 32'(r_underrun_cnt), 32'd1);
    $display("repeat: L=%h R=%h ur=%0d cnt=%0d", r_left_chan, r_right_chan, r_underrun, r_underrun_cnt);
    r_lrclk = 1'b1;

    // ---------------- async reset with frames queued ----------------
    for (int k = 1; k <= 6; k++) begin
      s_valid = 1'b1; s_left = 32'h9999_0000 + 32'(k); s_right = 32'h1234_0000 + 32'(k);
      step();
    end
    s_valid = 1'b0; lrclk = 1'b0;
    step();
    chk("pre-rst left", left_chan, 32'h9999_0001);
    chk("pre-rst level", 32'(fifo_level), 32'd5);
    lrclk = 1'b1;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async left", left_chan, 32'h0);
    chk("async right", right_chan, 32'h0);
    chk("async level", 32'(fifo_level), 32'd0);
    chk("async underrun", 32'(underrun), 32'd0);
    chk("async cnt", 32'(underrun_cnt), 32'd0);
    chk("async ready", 32'(s_ready), 32'd0);
    $display("async reset: L=%h level=%0d cnt=%0d", left_chan, fifo_level, underrun_cnt);
    step();
    rst_n = 1'b1;
    step();
    chk("re-rst ready", 32'(s_ready), 32'd1);
    chk("re-rst level", 32'(fifo_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
